mac_loader: RTL and testbench
=============================

# mac_loader

Transmit-side feeder for the MAC block. It accepts a coefficient set and then a sample stream from upstream valid/ready interfaces and drives the MAC's signal and coefficient FIFO write ports (data plus write strobe) under FIFO-full backpressure. It also counts frames of `NUM_TAPS` samples and reports load and frame status to the system controller.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of coefficient and sample words.
- `ADDR_LINES`, 4: MAC FIFO address width.
- `NUM_TAPS`, `2**ADDR_LINES`: coefficients per set and samples per frame. Legal range 1..`2**ADDR_LINES`.

Ports:
- `clk_i`, in, 1: clock, rising edge.
- `rstn_i`, in, 1: asynchronous reset, active low.
- `start_i`, in, 1: single-cycle pulse. Begins coefficient load. Honoured only in IDLE.
- `abort_i`, in, 1: single-cycle pulse. Returns the block to IDLE from any state.
- `coeff_valid_i`, in, 1: upstream coefficient valid.
- `coeff_data_i`, in, `DATA_WIDTH`: coefficient word.
- `coeff_ready_o`, out, 1: coefficient accepted this cycle when high together with `coeff_valid_i`.
- `sample_valid_i`, in, 1: upstream sample valid.
- `sample_data_i`, in, `DATA_WIDTH`: sample word.
- `sample_ready_o`, out, 1: sample accepted this cycle when high together with `sample_valid_i`.
- `full_adder_i`, in, 1: coefficient FIFO full.
- `full_mul_i`, in, 1: signal FIFO full.
- `coeff_fifo_o`, out, `DATA_WIDTH`: coefficient FIFO write data.
- `coeff_wr_o`, out, 1: coefficient FIFO write strobe.
- `signal_fifo_o`, out, `DATA_WIDTH`: signal FIFO write data.
- `sig_wr_o`, out, 1: signal FIFO write strobe.
- `busy_o`, out, 1: high in any state other than IDLE.
- `coeff_loaded_o`, out, 1: high while in STREAM.
- `frame_done_o`, out, 1: one-cycle pulse after the `NUM_TAPS`-th sample write of a frame.
- `tap_cnt_o`, out, `ADDR_LINES+1`: current coefficient or sample index within the set or frame.

## Operation
- FSM states: IDLE, LOAD, STREAM.
- IDLE:
  - Both ready outputs are 0.
  - `start_i` moves to LOAD and clears `tap_cnt_o`.
- LOAD:
  - `coeff_ready_o` = !`full_adder_i` && !`coeff_wr_o`.
  - Each handshake registers `coeff_data_i` into `coeff_fifo_o`, pulses `coeff_wr_o` on the next cycle, and increments `tap_cnt_o`.
  - The handshake that makes the count reach `NUM_TAPS` moves the FSM to STREAM and clears `tap_cnt_o`.
- STREAM:
  - `sample_ready_o` = !`full_mul_i` && !`sig_wr_o`.
  - Each handshake registers the sample into `signal_fifo_o`, pulses `sig_wr_o` on the next cycle, and increments `tap_cnt_o`.
  - At `NUM_TAPS` the counter wraps to 0 and `frame_done_o` pulses together with that sample's `sig_wr_o`.
  - STREAM persists until `abort_i`. Coefficients are not reloaded.
- Ready gating on the strobe prevents FIFO overrun, because the FIFO full flag lags a write by one cycle. Peak throughput is therefore one word every 2 cycles.
- Write data registers hold their last value when the strobe is low.
- `abort_i`:
  - Takes priority over every handshake in the same cycle. No word is accepted that cycle.
  - Next state is IDLE and the count clears.
  - A strobe already registered still issues; the write in flight completes.
- `start_i` outside IDLE is ignored.
- `coeff_valid_i` in STREAM and `sample_valid_i` in LOAD are ignored; the corresponding ready stays 0.

## Timing
- Reset values: state IDLE; all strobes, readies, `busy_o`, `coeff_loaded_o`, `frame_done_o` = 0; `tap_cnt_o` = 0; data outputs = 0.
- Latency: handshake at edge N, then strobe and data valid in cycle N+1 (one cycle).
- `busy_o` and `coeff_loaded_o` are registered state decodes. They change one cycle after the triggering edge.
- Readies are combinational from state, full inputs, and registered strobes.
- Asynchronous reset mid-LOAD or mid-STREAM clears everything immediately, including a pending strobe.

## Structure
- Package `mac_pkg`:
  - Typedef `loader_state_t` {IDLE, LOAD, STREAM}.
  - Shared `DATA_WIDTH` and `ADDR_LINES` defaults.
- One natural sub-module, `wr_port_reg`, instantiated twice (coefficient and signal): data register, strobe flop, and ready-gating logic for one FIFO write port.

## Test plan
- Reset then `start_i`, 16 back-to-back valid coefficients 1..16 -> `coeff_wr_o` pulses 16 times, every other cycle, data 1..16 in order; `coeff_loaded_o` rises one cycle after the 16th handshake.
- STREAM with 32 continuous samples -> 32 `sig_wr_o` pulses; `frame_done_o` pulses exactly twice, coincident with the writes of samples 16 and 32; `tap_cnt_o` wraps 15 -> 0.
- Hold `full_mul_i` = 1 for 5 cycles mid-frame -> `sample_ready_o` = 0 and no `sig_wr_o` for those 5 cycles; streaming resumes with no loss or duplication.
- `abort_i` in the same cycle as a coefficient handshake at count 7 -> no word accepted that cycle; the prior in-flight write completes; next state IDLE, `tap_cnt_o` = 0, `busy_o` falls.
- `start_i` pulsed in STREAM, plus `coeff_valid_i` held high -> no effect; `coeff_ready_o` stays 0.
- `rstn_i` asserted asynchronously while `sig_wr_o` = 1 -> all outputs reach their reset values before the next clock edge.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC transmit-side loader.
package mac_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_LINES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } loader_state_t;

endpackage

// File: rtl/mac_loader_if.sv
// Upstream streams, MAC FIFO write ports and controller status for mac_loader.
interface mac_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LINES = 4
);

    logic                  start_i;
    logic                  abort_i;
    logic                  coeff_valid_i;
    logic [DATA_WIDTH-1:0] coeff_data_i;
    logic                  coeff_ready_o;
    logic                  sample_valid_i;
    logic [DATA_WIDTH-1:0] sample_data_i;
    logic                  sample_ready_o;
    logic                  full_adder_i;
    logic                  full_mul_i;
    logic [DATA_WIDTH-1:0] coeff_fifo_o;
    logic                  coeff_wr_o;
    logic [DATA_WIDTH-1:0] signal_fifo_o;
    logic                  sig_wr_o;
    logic                  busy_o;
    logic                  coeff_loaded_o;
    logic                  frame_done_o;
    logic [ADDR_LINES:0]   tap_cnt_o;

    modport slave (
        input  start_i, abort_i,
        input  coeff_valid_i, coeff_data_i,
        input  sample_valid_i, sample_data_i,
        input  full_adder_i, full_mul_i,
        output coeff_ready_o, sample_ready_o,
        output coeff_fifo_o, coeff_wr_o,
        output signal_fifo_o, sig_wr_o,
        output busy_o, coeff_loaded_o, frame_done_o, tap_cnt_o
    );

    modport master (
        output start_i, abort_i,
        output coeff_valid_i, coeff_data_i,
        output sample_valid_i, sample_data_i,
        output full_adder_i, full_mul_i,
        input  coeff_ready_o, sample_ready_o,
        input  coeff_fifo_o, coeff_wr_o,
        input  signal_fifo_o, sig_wr_o,
        input  busy_o, coeff_loaded_o, frame_done_o, tap_cnt_o
    );

endinterface

// File: rtl/wr_port_reg.sv
// One MAC FIFO write port: ready gating, registered write data and strobe.
module wr_port_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  port_en_i,
    input  logic                  abort_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  full_i,
    output logic                  ready_o,
    output logic                  accept_o,
    output logic                  wr_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  ready;
    logic                  accept;

    // The full flag lags a write by a cycle, so a pending strobe blocks the next word.
    always_comb begin
        ready  = port_en_i && !full_i && !wr_q;
        accept = ready && valid_i && !abort_i;
        wr_d   = accept;
        data_d = accept ? data_i : data_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_q   <= 1'b0;
            data_q <= '0;
        end else begin
            wr_q   <= wr_d;
            data_q <= data_d;
        end
    end

    assign ready_o  = ready;
    assign accept_o = accept;
    assign wr_o     = wr_q;
    assign data_o   = data_q;

endmodule

// File: rtl/mac_loader.sv
// Feeds a coefficient set then a framed sample stream into the MAC write FIFOs.
//
//   state  | meaning
//   IDLE   | waiting for start_i, both readies low
//   LOAD   | accepting NUM_TAPS coefficients into the coefficient FIFO
//   STREAM | accepting samples forever, frame_done_o every NUM_TAPS writes
module mac_loader
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_LINES = ADDR_LINES_DEF,
    parameter int NUM_TAPS   = 2**ADDR_LINES
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    mac_loader_if.slave  bus
);

    localparam int            CW     = ADDR_LINES + 1;
    localparam logic [CW-1:0] TAPS_C = CW'(NUM_TAPS);

    loader_state_t state_q, state_d;
    logic [CW-1:0] tap_cnt_q, tap_cnt_d;
    logic [CW-1:0] tap_cnt_inc;
    logic          busy_q, busy_d;
    logic          loaded_q, loaded_d;
    logic          frame_done_q, frame_done_d;
    logic          load_en, stream_en;
    logic          coeff_accept, sample_accept;

    assign load_en   = (state_q == LOAD);
    assign stream_en = (state_q == STREAM);

    wr_port_reg #(.DATA_WIDTH(DATA_WIDTH)) u_coeff_port (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .port_en_i (load_en),
        .abort_i   (bus.abort_i),
        .valid_i   (bus.coeff_valid_i),
        .data_i    (bus.coeff_data_i),
        .full_i    (bus.full_adder_i),
        .ready_o   (bus.coeff_ready_o),
        .accept_o  (coeff_accept),
        .wr_o      (bus.coeff_wr_o),
        .data_o    (bus.coeff_fifo_o)
    );

    wr_port_reg #(.DATA_WIDTH(DATA_WIDTH)) u_signal_port (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .port_en_i (stream_en),
        .abort_i   (bus.abort_i),
        .valid_i   (bus.sample_valid_i),
        .data_i    (bus.sample_data_i),
        .full_i    (bus.full_mul_i),
        .ready_o   (bus.sample_ready_o),
        .accept_o  (sample_accept),
        .wr_o      (bus.sig_wr_o),
        .data_o    (bus.signal_fifo_o)
    );

    always_comb begin
        state_d      = state_q;
        tap_cnt_d    = tap_cnt_q;
        frame_done_d = 1'b0;
        tap_cnt_inc  = tap_cnt_q + CW'(1);
        // Status flags are decodes of the current state, so they trail it by a cycle.
        busy_d       = (state_q != IDLE);
        loaded_d     = (state_q == STREAM);

        if (bus.abort_i) begin
            state_d   = IDLE;
            tap_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        state_d   = LOAD;
                        tap_cnt_d = '0;
                    end
                end
                LOAD: begin
                    if (coeff_accept) begin
                        if (tap_cnt_inc == TAPS_C) begin
                            state_d   = STREAM;
                            tap_cnt_d = '0;
                        end else begin
                            tap_cnt_d = tap_cnt_inc;
                        end
                    end
                end
                STREAM: begin
                    if (sample_accept) begin
                        if (tap_cnt_inc == TAPS_C) begin
                            tap_cnt_d    = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            tap_cnt_d = tap_cnt_inc;
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    tap_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            tap_cnt_q    <= '0;
            busy_q       <= 1'b0;
            loaded_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tap_cnt_q    <= tap_cnt_d;
            busy_q       <= busy_d;
            loaded_q     <= loaded_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.busy_o         = busy_q;
    assign bus.coeff_loaded_o = loaded_q;
    assign bus.frame_done_o   = frame_done_q;
    assign bus.tap_cnt_o      = tap_cnt_q;

endmodule

// File: tb/tb_mac_loader.sv
// Randomized directed bench for mac_loader against a phase/count reference model.
module tb_mac_loader;

    localparam int DW = 32;
    localparam int AL = 4;
    localparam int NT = 16;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;

    always #5 clk_i = ~clk_i;

    mac_loader_if #(.DATA_WIDTH(DW), .ADDR_LINES(AL)) bus ();

    mac_loader #(.DATA_WIDTH(DW), .ADDR_LINES(AL), .NUM_TAPS(NT)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 loading, 2 streaming.
    int          m_phase;
    int          m_cnt;
    int          m_samples;
    bit          m_cwr, m_swr, m_fd, m_busy, m_loaded;
    logic [31:0] m_cdata, m_sdata;
    int          cwr_seen, swr_seen, fd_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_phase = 0; m_cnt = 0; m_samples = 0;
        m_cwr = 0; m_swr = 0; m_fd = 0; m_busy = 0; m_loaded = 0;
        m_cdata = '0; m_sdata = '0;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_coeff_ready"}, 32'(bus.coeff_ready_o), 0);
        chk({pfx, "_sample_ready"}, 32'(bus.sample_ready_o), 0);
        chk({pfx, "_coeff_wr"}, 32'(bus.coeff_wr_o), 0);
        chk({pfx, "_sig_wr"}, 32'(bus.sig_wr_o), 0);
        chk({pfx, "_coeff_fifo"}, bus.coeff_fifo_o, 0);
        chk({pfx, "_signal_fifo"}, bus.signal_fifo_o, 0);
        chk({pfx, "_busy"}, 32'(bus.busy_o), 0);
        chk({pfx, "_loaded"}, 32'(bus.coeff_loaded_o), 0);
        chk({pfx, "_frame_done"}, 32'(bus.frame_done_o), 0);
        chk({pfx, "_tap_cnt"}, 32'(bus.tap_cnt_o), 0);
    endtask

    // One clock: check outputs mid-cycle, advance the model, step past the edge.
    task automatic cycle();
        bit exp_cr, exp_sr, acc_c, acc_s;
        int prev_phase;
        @(negedge clk_i);
        exp_cr = (m_phase == 1) && !bus.full_adder_i && !m_cwr;
        exp_sr = (m_phase == 2) && !bus.full_mul_i && !m_swr;
        if (!bus.abort_i) begin
            chk("coeff_ready", 32'(bus.coeff_ready_o), 32'(exp_cr));
            chk("sample_ready", 32'(bus.sample_ready_o), 32'(exp_sr));
        end
        chk("coeff_wr", 32'(bus.coeff_wr_o), 32'(m_cwr));
        chk("sig_wr", 32'(bus.sig_wr_o), 32'(m_swr));
        chk("coeff_fifo", bus.coeff_fifo_o, m_cdata);
        chk("signal_fifo", bus.signal_fifo_o, m_sdata);
        chk("frame_done", 32'(bus.frame_done_o), 32'(m_fd));
        chk("busy", 32'(bus.busy_o), 32'(m_busy));
        chk("coeff_loaded", 32'(bus.coeff_loaded_o), 32'(m_loaded));
        chk("tap_cnt", 32'(bus.tap_cnt_o), 32'(m_cnt));
        if (bus.coeff_wr_o === 1'b1) cwr_seen++;
        if (bus.sig_wr_o === 1'b1) swr_seen++;
        if (bus.frame_done_o === 1'b1) fd_seen++;

        acc_c = exp_cr && bus.coeff_valid_i && !bus.abort_i;
        acc_s = exp_sr && bus.sample_valid_i && !bus.abort_i;
        prev_phase = m_phase;
        m_cwr = acc_c;
        m_swr = acc_s;
        m_fd  = 0;
        if (acc_c) m_cdata = bus.coeff_data_i;
        if (acc_s) m_sdata = bus.sample_data_i;
        if (bus.abort_i) begin
            m_phase = 0;
            m_cnt   = 0;
        end else if (m_phase == 0) begin
            if (bus.start_i) begin
                m_phase = 1;
                m_cnt   = 0;
            end
        end else if (m_phase == 1) begin
            if (acc_c) begin
                m_cnt++;
                if (m_cnt == NT) begin
                    m_phase = 2;
                    m_cnt   = 0;
                end
            end
        end else if (acc_s) begin
            m_samples++;
            m_cnt = (m_cnt + 1) % NT;
            m_fd  = (m_cnt == 0);
        end
        m_busy   = (prev_phase != 0);
        m_loaded = (prev_phase == 2);
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_coeffs();
        bus.coeff_valid_i = 1'b1;
        for (int i = 0; i < 200 && m_phase == 1; i++) begin
            bus.coeff_data_i = 32'(m_cnt + 1);
            cycle();
        end
        bus.coeff_valid_i = 1'b0;
    endtask

    initial begin
        int base;
        bus.start_i = 0; bus.abort_i = 0;
        bus.coeff_valid_i = 0; bus.coeff_data_i = '0;
        bus.sample_valid_i = 0; bus.sample_data_i = '0;
        bus.full_adder_i = 0; bus.full_mul_i = 0;
        m_reset();
        cwr_seen = 0; swr_seen = 0; fd_seen = 0;

        #12;
        chk_all_zero("reset");
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Valids in IDLE must not be accepted.
        bus.coeff_valid_i = 1; bus.sample_valid_i = 1;
        cycle(); cycle();
        bus.coeff_valid_i = 0; bus.sample_valid_i = 0;

        bus.start_i = 1; cycle(); bus.start_i = 0;
        load_coeffs();
        cycle(); cycle();
        chk("coeff_writes", 32'(cwr_seen), NT);
        chk("loaded_high", 32'(bus.coeff_loaded_o), 1);

        // Two full frames of continuous samples.
        swr_seen = 0; fd_seen = 0;
        bus.sample_valid_i = 1;
        for (int i = 0; i < 200 && m_samples < 2 * NT; i++) begin
            bus.sample_data_i = $urandom;
            cycle();
        end
        bus.sample_valid_i = 0;
        cycle(); cycle();
        chk("sample_writes", 32'(swr_seen), 2 * NT);
        chk("frame_pulses", 32'(fd_seen), 2);

        // Backpressure on the signal FIFO mid-frame.
        bus.sample_valid_i = 1;
        for (int i = 0; i < 5; i++) begin
            bus.sample_data_i = $urandom;
            cycle();
        end
        for (int i = 0; i < 10 && m_swr; i++) cycle();
        base = swr_seen;
        bus.full_mul_i = 1;
        for (int i = 0; i < 5; i++) begin
            bus.sample_data_i = $urandom;
            cycle();
        end
        chk("full_no_writes", 32'(swr_seen - base), 0);
        bus.full_mul_i = 0;
        for (int i = 0; i < 12; i++) begin
            bus.sample_data_i = $urandom;
            cycle();
        end

        // Random valid/full traffic; coefficient side must stay idle.
        for (int i = 0; i < 120; i++) begin
            bus.sample_valid_i = 1'($urandom_range(0, 1));
            bus.sample_data_i  = $urandom;
            bus.full_mul_i     = ($urandom_range(0, 3) == 0);
            bus.coeff_valid_i  = 1'($urandom_range(0, 1));
            bus.coeff_data_i   = $urandom;
            bus.full_adder_i   = 1'($urandom_range(0, 1));
            cycle();
        end
        bus.full_mul_i = 0; bus.full_adder_i = 0; bus.sample_valid_i = 0;

        // start_i in STREAM with coefficients offered is ignored.
        bus.coeff_valid_i = 1;
        bus.start_i = 1; cycle(); bus.start_i = 0;
        for (int i = 0; i < 3; i++) cycle();
        bus.coeff_valid_i = 0;
        chk("stream_kept", 32'(bus.coeff_loaded_o), 1);

        // Abort while a sample write is in flight: the write still issues.
        bus.sample_valid_i = 1;
        cycle();
        for (int i = 0; i < 10 && !m_swr; i++) begin
            bus.sample_data_i = $urandom;
            cycle();
        end
        bus.abort_i = 1; cycle(); bus.abort_i = 0;
        bus.sample_valid_i = 0;
        cycle(); cycle();
        chk("abort_stream_busy", 32'(bus.busy_o), 0);

        // Abort coincident with a coefficient handshake at count 7.
        base = cwr_seen;
        bus.start_i = 1; cycle(); bus.start_i = 0;
        bus.coeff_valid_i = 1;
        for (int i = 0; i < 60 && !(m_cnt == 7 && !m_cwr); i++) begin
            bus.coeff_data_i = $urandom;
            cycle();
        end
        bus.coeff_data_i = $urandom;
        bus.abort_i = 1; cycle(); bus.abort_i = 0;
        bus.coeff_valid_i = 0;
        cycle(); cycle();
        chk("abort_load_writes", 32'(cwr_seen - base), 7);
        chk("abort_load_cnt", 32'(bus.tap_cnt_o), 0);
        chk("abort_load_busy", 32'(bus.busy_o), 0);

        // Asynchronous reset while a sample strobe is high.
        bus.start_i = 1; cycle(); bus.start_i = 0;
        load_coeffs();
        bus.sample_valid_i = 1;
        for (int i = 0; i < 10 && !m_swr; i++) begin
            bus.sample_data_i = $urandom;
            cycle();
        end
        chk("pre_reset_sig_wr", 32'(bus.sig_wr_o), 1);
        #2;
        rstn_i = 1'b0;
        #1;
        chk_all_zero("async_reset");
        bus.sample_valid_i = 0;
        @(posedge clk_i);
        #2;
        rstn_i = 1'b1;
        m_reset();
        @(posedge clk_i);
        #1;
        cycle(); cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
